// File: rtl/vga_sync_gen_if.sv
// Renderer-facing and pin-facing signals of the VGA timing generator.
// master: the timing generator; slave: the renderer / pin consumer.
interface vga_sync_gen_if;
  logic [2:0] rgb_in;
  logic       p_tick;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       video_on;
  logic       frame_start;
  logic       hsync;
  logic       vsync;
  logic [2:0] rgb_out;

  modport master (
    input  rgb_in,
    output p_tick, pixel_x, pixel_y, video_on, frame_start,
           hsync, vsync, rgb_out
  );

  modport slave (
    output rgb_in,
    input  p_tick, pixel_x, pixel_y, video_on, frame_start,
           hsync, vsync, rgb_out
  );
endinterface

// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA timing generator: pixel divider, h/v counters and a
// registered pin stage keeping colour and sync aligned one pixel behind.
module vga_sync_gen #(
  parameter int HD  = 640,
  parameter int HF  = 16,
  parameter int HB  = 48,
  parameter int HR  = 96,
  parameter int VD  = 480,
  parameter int VF  = 10,
  parameter int VB  = 33,
  parameter int VR  = 2,
  parameter int DIV = 4
) (
  input  logic           clk,
  input  logic           rst,
  vga_sync_gen_if.master vga
);

  localparam int HT = HD + HF + HB + HR;
  localparam int VT = VD + VF + VB + VR;
  localparam int DW = $clog2(DIV);

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [9:0]    H_LAST   = 10'(HT - 1);
  localparam logic [9:0]    V_LAST   = 10'(VT - 1);
  localparam logic [9:0]    H_VIS    = 10'(HD);
  localparam logic [9:0]    V_VIS    = 10'(VD);
  localparam logic [9:0]    HS_BEG   = 10'(HD + HF);
  localparam logic [9:0]    HS_END   = 10'(HD + HF + HR - 1);
  localparam logic [9:0]    VS_BEG   = 10'(VD + VF);
  localparam logic [9:0]    VS_END   = 10'(VD + VF + VR - 1);

  logic [DW-1:0] div_cnt;
  logic [9:0]    h_cnt;
  logic [9:0]    v_cnt;
  logic          p_tick;
  logic          frame_start;
  logic          hsync;
  logic          vsync;
  logic [2:0]    rgb_out;
  logic          h_end;
  logic          v_end;
  logic          video_on;

  assign h_end    = (h_cnt == H_LAST);
  assign v_end    = (v_cnt == V_LAST);
  assign video_on = (h_cnt < H_VIS) && (v_cnt < V_VIS);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt     <= '0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      p_tick      <= 1'b0;
      frame_start <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      rgb_out     <= '0;
    end else begin
      div_cnt     <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DW'(1);
      p_tick      <= (div_cnt == DIV_LAST);
      frame_start <= p_tick && h_end && v_end;
      // Pin stage samples the same tick that advances the counters, so the
      // pins always describe the pixel whose coordinates were just left.
      if (p_tick) begin
        h_cnt <= h_end ? '0 : h_cnt + 10'd1;
        if (h_end) begin
          v_cnt <= v_end ? '0 : v_cnt + 10'd1;
        end
        hsync   <= ~((h_cnt >= HS_BEG) && (h_cnt <= HS_END));
        vsync   <= ~((v_cnt >= VS_BEG) && (v_cnt <= VS_END));
        rgb_out <= video_on ? vga.rgb_in : 3'b000;
      end
    end
  end

  assign vga.p_tick      = p_tick;
  assign vga.pixel_x     = h_cnt;
  assign vga.pixel_y     = v_cnt;
  assign vga.video_on    = video_on;
  assign vga.frame_start = frame_start;
  assign vga.hsync       = hsync;
  assign vga.vsync       = vsync;
  assign vga.rgb_out     = rgb_out;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: default-geometry instance for line/reset timing, small
// geometry instance (32x19, DIV=3) so whole-frame behaviour fits the run.
module tb_vga_sync_gen;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  vga_sync_gen_if d_if ();
  vga_sync_gen_if s_if ();

  vga_sync_gen u_dut (
    .clk (clk),
    .rst (rst),
    .vga (d_if)
  );

  vga_sync_gen #(
    .HD (16), .HF (4), .HB (6), .HR (6),
    .VD (12), .VF (2), .VB (3), .VR (2),
    .DIV(3)
  ) u_small (
    .clk (clk),
    .rst (rst),
    .vga (s_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Runs from reset release for 3210 clks: one full default line plus one
  // full frame of the small instance, then compares collected statistics.
  task automatic run_window();
    int d_k = 0, d_last = 0, d_perr = 0, d_xerr = 0, d_rerr = 0, d_pre = 0;
    int d_hlow = 0, d_hfirst = -1, d_verr = 0, d_fs = 0;
    int s_k = 0, s_last = 0, s_perr = 0, s_xerr = 0, s_rerr = 0;
    int s_hlow = 0, s_vlow = 0, s_vx = -1, s_vy = -1;
    int s_fs = 0, s_fs_clk = -1, s_fs_x = -1, s_fs_y = -1;
    int x, y, px, py, rexp;
    bit von;
    for (int c = 1; c <= 3210; c++) begin
      @(posedge clk); #1;
      if (d_if.frame_start) d_fs++;
      if (s_if.frame_start) begin
        s_fs++;
        s_fs_clk = c;
        s_fs_x   = int'(s_if.pixel_x);
        s_fs_y   = int'(s_if.pixel_y);
      end
      if (d_if.vsync !== 1'b1) d_verr++;
      if (d_if.p_tick) begin
        if (d_k == 0) begin
          check("d_first_tick_clk", c, 4);
          check("d_first_x", d_if.pixel_x, 0);
          check("d_first_y", d_if.pixel_y, 0);
          check("d_first_video_on", d_if.video_on, 1);
          check("d_first_rgb_blank", d_if.rgb_out, 0);
          check("d_first_hsync", d_if.hsync, 1);
          d_if.rgb_in = 3'b101;
        end else begin
          if (c - d_last != 4) d_perr++;
          px   = (d_k - 1) % 800;
          rexp = (px < 640) ? 5 : 0;
          if (int'(d_if.rgb_out) != rexp) d_rerr++;
          if (d_if.hsync === 1'b0) begin
            if (d_hlow == 0) d_hfirst = int'(d_if.pixel_x);
            d_hlow++;
          end
        end
        x   = d_k % 800;
        y   = d_k / 800;
        von = (x < 640) && (y < 480);
        if (int'(d_if.pixel_x) != x || int'(d_if.pixel_y) != y || d_if.video_on !== von)
          d_xerr++;
        d_last = c;
        d_k++;
      end else if (d_k == 0) begin
        if (d_if.hsync !== 1'b1 || d_if.rgb_out !== 3'b000) d_pre++;
      end
      if (s_if.p_tick) begin
        if (s_k == 0) check("s_first_tick_clk", c, 3);
        else if (c - s_last != 3) s_perr++;
        x   = s_k % 32;
        y   = (s_k / 32) % 19;
        von = (x < 16) && (y < 12);
        if (int'(s_if.pixel_x) != x || int'(s_if.pixel_y) != y || s_if.video_on !== von)
          s_xerr++;
        if (s_k >= 1) begin
          px   = (s_k - 1) % 32;
          py   = ((s_k - 1) / 32) % 19;
          rexp = (px < 16 && py < 12) ? 5 : 0;
          if (int'(s_if.rgb_out) != rexp) s_rerr++;
        end else if (s_if.rgb_out !== 3'b000) s_rerr++;
        if (s_k >= 1 && s_k <= 608) begin
          if (s_if.hsync === 1'b0) s_hlow++;
          if (s_if.vsync === 1'b0) begin
            if (s_vlow == 0) begin
              s_vx = int'(s_if.pixel_x);
              s_vy = int'(s_if.pixel_y);
            end
            s_vlow++;
          end
        end
        s_last = c;
        s_k++;
      end
    end
    check("d_pre_tick_outputs", d_pre, 0);
    check("d_tick_count", d_k, 802);
    check("d_tick_period", d_perr, 0);
    check("d_xy_video_on_seq", d_xerr, 0);
    check("d_rgb_line", d_rerr, 0);
    check("d_hsync_low_pixels", d_hlow, 96);
    check("d_hsync_first_low_x", d_hfirst, 657);
    check("d_vsync_high", d_verr, 0);
    check("d_no_frame_start", d_fs, 0);
    check("s_tick_period", s_perr, 0);
    check("s_xy_video_on_seq", s_xerr, 0);
    check("s_rgb_frame", s_rerr, 0);
    check("s_hsync_low_frame", s_hlow, 114);
    check("s_vsync_low_frame", s_vlow, 64);
    check("s_vsync_first_x", s_vx, 1);
    check("s_vsync_first_y", s_vy, 14);
    check("s_frame_start_count", s_fs, 1);
    check("s_frame_start_clk", s_fs_clk, 1825);
    check("s_frame_start_x", s_fs_x, 0);
    check("s_frame_start_y", s_fs_y, 0);
  endtask

  task automatic glitch(input string tag, input logic [2:0] good, input logic [2:0] bad);
    bit found = 0;
    d_if.rgb_in = bad;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (d_if.p_tick) begin
        found = 1;
        break;
      end
    end
    check({tag, "_tick_seen"}, found, 1);
    d_if.rgb_in = good;
    @(posedge clk); #1;
    d_if.rgb_in = bad;
    check({tag, "_captured"}, d_if.rgb_out, good);
    @(posedge clk); #1;
    check({tag, "_held"}, d_if.rgb_out, good);
  endtask

  initial begin
    bit found;
    d_if.rgb_in = 3'b111;
    s_if.rgb_in = 3'b101;
    rst = 1'b1;
    #1 rst = 1'b0;
    #22;
    check("rst_hsync", d_if.hsync, 1);
    check("rst_vsync", d_if.vsync, 1);
    check("rst_rgb", d_if.rgb_out, 0);
    check("rst_p_tick", d_if.p_tick, 0);
    check("rst_frame_start", d_if.frame_start, 0);
    check("rst_x", d_if.pixel_x, 0);
    check("rst_y", d_if.pixel_y, 0);
    @(negedge clk);
    rst = 1'b1;
    run_window();

    // Advance to pixel (700,1) where hsync is low, then reset between edges.
    found = 0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      if (d_if.p_tick && d_if.pixel_x == 10'd700) begin
        found = 1;
        break;
      end
    end
    check("reach_x700", found, 1);
    check("reach_y", d_if.pixel_y, 1);
    check("hsync_low_before_reset", d_if.hsync, 0);
    #2 rst = 1'b0;
    #1;
    check("async_rst_hsync", d_if.hsync, 1);
    check("async_rst_vsync", d_if.vsync, 1);
    check("async_rst_x", d_if.pixel_x, 0);
    check("async_rst_y", d_if.pixel_y, 0);
    check("async_rst_p_tick", d_if.p_tick, 0);
    d_if.rgb_in = 3'b111;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    run_window();

    glitch("glitch_a", 3'b110, 3'b001);
    glitch("glitch_b", 3'b011, 3'b100);
    #2 rst = 1'b0;
    #1;
    check("async_rst_rgb_blank", d_if.rgb_out, 0);
    check("async_rst_hsync_2", d_if.hsync, 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("post_reset_first_tick", d_if.p_tick, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
